// File: rtl/alu_shifter_pkg.sv
// Shared types for the sequential shifter/rotator: Z80 CB-group shift modes and FSM states.
package alu_shifter_pkg;

    typedef enum logic [2:0] {
        RLC = 3'd0,
        RRC = 3'd1,
        RL  = 3'd2,
        RR  = 3'd3,
        SLA = 3'd4,
        SRA = 3'd5,
        SLL = 3'd6,
        SRL = 3'd7
    } shift_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Even encodings (RLC, RL, SLA, SLL) shift towards the MSB.
    function automatic logic is_left(input shift_mode_t m);
        return ~m[0];
    endfunction

endpackage

// File: rtl/alu_shifter_step.sv
// Combinational single-bit rotate/shift step over WIDTH bits with carry in/out.
module alu_shifter_step
    import alu_shifter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d_i,
    input  logic             c_i,
    input  shift_mode_t      mode_i,
    output logic [WIDTH-1:0] d_o,
    output logic             c_o
);

    logic in_bit;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        in_bit = 1'b0;
        case (mode_i)
            RLC:     in_bit = d_i[WIDTH-1];
            RRC:     in_bit = d_i[0];
            RL:      in_bit = c_i;
            RR:      in_bit = c_i;
            SLA:     in_bit = 1'b0;
            SRA:     in_bit = d_i[WIDTH-1];
            SLL:     in_bit = 1'b1;
            SRL:     in_bit = 1'b0;
            default: in_bit = 1'b0;
        endcase

        if (is_left(mode_i)) begin
            d_o = {d_i[WIDTH-2:0], in_bit};
            c_o = d_i[WIDTH-1];
        end else begin
            d_o = {in_bit, d_i[WIDTH-1:1]};
            c_o = d_i[0];
        end
    end

endmodule

// File: rtl/alu_shifter_seq.sv
// Multi-mode sequential shifter/rotator with start/busy/done handshake.
// Define ALU_SHIFTER_BARREL_EN for the single-pass barrel build; default iterates one bit per clock.
module alu_shifter_seq
    import alu_shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] count,
    input  logic [WIDTH-1:0] db_in,
    input  logic             cy_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] db_out,
    output logic             cy_out,
    output logic             sign_out,
    output logic             zero_out,
    output logic             parity_out
);

    state_t           state_q;
    logic [WIDTH-1:0] data_q;
    logic             carry_q;

`ifdef ALU_SHIFTER_BARREL_EN
    localparam int MAX_STEPS = (1 << CNT_W) - 1;

    // Stage k holds the operand after k single-bit steps; count picks the stage.
    logic [MAX_STEPS:0][WIDTH-1:0] chain_d;
    logic [MAX_STEPS:0]            chain_c;

    assign chain_d[0] = db_in;
    assign chain_c[0] = cy_in;

    for (genvar k = 0; k < MAX_STEPS; k++) begin : g_stage
        alu_shifter_step #(.WIDTH(WIDTH)) u_step (
            .d_i    (chain_d[k]),
            .c_i    (chain_c[k]),
            .mode_i (shift_mode_t'(mode)),
            .d_o    (chain_d[k+1]),
            .c_o    (chain_c[k+1])
        );
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            data_q  <= '0;
            carry_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            case (state_q)
                IDLE: if (start) begin
                    data_q  <= chain_d[count];
                    carry_q <= chain_c[count];
                    state_q <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
`else
    shift_mode_t      mode_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] step_d;
    logic             step_c;

    alu_shifter_step #(.WIDTH(WIDTH)) u_step (
        .d_i    (data_q),
        .c_i    (carry_q),
        .mode_i (mode_q),
        .d_o    (step_d),
        .c_o    (step_c)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            data_q  <= '0;
            carry_q <= 1'b0;
            mode_q  <= RLC;
            cnt_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            case (state_q)
                IDLE: if (start) begin
                    data_q  <= db_in;
                    carry_q <= cy_in;
                    mode_q  <= shift_mode_t'(mode);
                    cnt_q   <= count;
                    state_q <= (count != '0) ? SHIFT : DONE;
                end
                SHIFT: begin
                    data_q  <= step_d;
                    carry_q <= step_c;
                    cnt_q   <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) state_q <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
`endif

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign db_out     = data_q;
    assign cy_out     = carry_q;
    assign sign_out   = data_q[WIDTH-1];
    assign zero_out   = (data_q == '0);
    assign parity_out = ~^data_q;

endmodule

// File: tb/tb_alu_shifter_seq.sv
// Directed table-driven bench for alu_shifter_seq (WIDTH=8, CNT_W=3), either build.
module tb_alu_shifter_seq;

    localparam int WIDTH = 8;
    localparam int CNT_W = 3;
    localparam int TIMEOUT = 40;

    logic             clk;
    logic             nreset;
    logic             start;
    logic [2:0]       mode;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] db_in;
    logic             cy_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] db_out;
    logic             cy_out;
    logic             sign_out;
    logic             zero_out;
    logic             parity_out;

    int n_tests = 0;
    int n_fail  = 0;

    alu_shifter_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .start      (start),
        .mode       (mode),
        .count      (count),
        .db_in      (db_in),
        .cy_in      (cy_in),
        .busy       (busy),
        .done       (done),
        .db_out     (db_out),
        .cy_out     (cy_out),
        .sign_out   (sign_out),
        .zero_out   (zero_out),
        .parity_out (parity_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [2:0]       mode;
        logic [CNT_W-1:0] count;
        logic [WIDTH-1:0] db;
        logic             cy;
        logic [WIDTH-1:0] exp_db;
        logic             exp_cy;
        logic             exp_sign;
        logic             exp_zero;
        logic             exp_par;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int exp_latency(input logic [CNT_W-1:0] c);
`ifdef ALU_SHIFTER_BARREL_EN
        return 1;
`else
        return int'(c) + 1;
`endif
    endfunction

    // Issue one operation at a negedge, then sample #1 after each posedge until done.
    task automatic run_op(input vec_t v, input logic inject_start);
        int lat;
        int busy_cycles;
        logic seen;
        lat = 0;
        busy_cycles = 0;
        seen = 1'b0;
        @(negedge clk);
        start = 1'b1;
        mode  = v.mode;
        count = v.count;
        db_in = v.db;
        cy_in = v.cy;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(posedge clk);
            #1;
            lat++;
            // Optional second request held across the first post-accept edge.
            start = (inject_start && lat == 1);
            mode  = 3'd0;
            count = '1;
            db_in = 8'hA5;
            cy_in = 1'b0;
            if (busy) busy_cycles++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check({v.name, " done seen"}, 32'(seen), 32'd1);
        check({v.name, " latency"}, lat, exp_latency(v.count));
        check({v.name, " busy cycles"}, busy_cycles, exp_latency(v.count));
        check({v.name, " db_out"}, 32'(db_out), 32'(v.exp_db));
        check({v.name, " cy_out"}, 32'(cy_out), 32'(v.exp_cy));
        check({v.name, " flags s/z/p"}, {sign_out, zero_out, parity_out},
              {v.exp_sign, v.exp_zero, v.exp_par});
        @(posedge clk);
        #1;
        check({v.name, " done one cycle"}, {busy, done}, 2'b00);
        check({v.name, " db_out held"}, 32'(db_out), 32'(v.exp_db));
    endtask

    function automatic vec_t mk(input string n, input logic [2:0] m, input int c,
                                input logic [7:0] d, input logic cy,
                                input logic [7:0] ed, input logic ec,
                                input logic es, input logic ez, input logic ep);
        vec_t v;
        v.name = n; v.mode = m; v.count = CNT_W'(c); v.db = d; v.cy = cy;
        v.exp_db = ed; v.exp_cy = ec; v.exp_sign = es; v.exp_zero = ez; v.exp_par = ep;
        return v;
    endfunction

    initial begin
        int extra_done;
        vec_t v;

        //            name        mode  cnt db     cy    exp_db exp_cy sign zero par
        vecs.push_back(mk("rlc81",  3'd0, 1, 8'h81, 1'b0, 8'h03, 1'b1, 0, 0, 1));
        vecs.push_back(mk("rl80",   3'd2, 2, 8'h80, 1'b0, 8'h01, 1'b0, 0, 0, 0));
        vecs.push_back(mk("sra80",  3'd5, 3, 8'h80, 1'b0, 8'hF0, 1'b0, 1, 0, 1));
        vecs.push_back(mk("srl01",  3'd7, 1, 8'h01, 1'b0, 8'h00, 1'b1, 0, 1, 1));
        vecs.push_back(mk("sll00",  3'd6, 2, 8'h00, 1'b0, 8'h03, 1'b0, 0, 0, 1));
        vecs.push_back(mk("rr01",   3'd3, 1, 8'h01, 1'b1, 8'h80, 1'b1, 1, 0, 0));
        vecs.push_back(mk("cnt0",   3'd4, 0, 8'h55, 1'b1, 8'h55, 1'b1, 0, 0, 1));
        vecs.push_back(mk("rrc7",   3'd1, 7, 8'h01, 1'b0, 8'h02, 1'b0, 0, 0, 0));
        vecs.push_back(mk("slaFF",  3'd4, 7, 8'hFF, 1'b0, 8'h80, 1'b1, 1, 0, 0));
        vecs.push_back(mk("rl9bit", 3'd2, 7, 8'h00, 1'b1, 8'h40, 1'b0, 0, 0, 0));

        start = 1'b0; mode = 3'd0; count = '0; db_in = '0; cy_in = 1'b0;
        nreset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy/done", {busy, done}, 2'b00);
        check("reset db/cy", {db_out, cy_out}, 9'h000);
        check("reset flags s/z/p", {sign_out, zero_out, parity_out}, 3'b011);
        @(negedge clk);
        nreset = 1'b1;

        foreach (vecs[i]) run_op(vecs[i], 1'b0);

        // Second start during busy: ignored, single done, result unaffected.
        v = mk("busy_start", 3'd0, 3, 8'h81, 1'b0, 8'h0C, 1'b0, 0, 0, 1);
        run_op(v, 1'b1);
        extra_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) extra_done++;
        end
        check("busy_start no extra done", extra_done, 0);

        // Reset mid-operation abandons it without a done pulse.
        @(negedge clk);
        start = 1'b1; mode = 3'd0; count = 3'd7; db_in = 8'h81; cy_in = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nreset = 1'b0;
        #1;
        check("midreset busy/done", {busy, done}, 2'b00);
        check("midreset db/cy", {db_out, cy_out}, 9'h000);
        @(negedge clk);
        nreset = 1'b1;
        extra_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) extra_done++;
        end
        check("midreset stays idle", extra_done, 0);

        run_op(mk("post_reset", 3'd1, 2, 8'h03, 1'b0, 8'hC0, 1'b1, 1, 0, 1), 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_shifter_seq.md
Name: alu_shifter_seq

Overview:
- Parametrised, multi-mode sequential shifter/rotator; next generation of the ALU shifter core.
- Supports all eight Z80 CB-group rotate/shift modes over WIDTH bits, with a programmable shift count of 0..2^CNT_W-1.
- Default build iterates one bit per clock under a start/busy/done handshake.
- Sits beside the ALU core; the sequencer issues an operation and samples the result and flags on done.

Parameters:
- WIDTH, 8: data width in bits; minimum 2.
- CNT_W, 3: width of the shift-count input.

Ports:
- clk  in  1  system clock.
- nreset  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  3  0 RLC, 1 RRC, 2 RL, 3 RR, 4 SLA, 5 SRA, 6 SLL, 7 SRL.
- count  in  CNT_W  number of single-bit steps.
- db_in  in  WIDTH  operand.
- cy_in  in  1  carry flag in.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when the result is valid.
- db_out  out  WIDTH  result register.
- cy_out  out  1  carry out (last bit shifted out).
- sign_out  out  1  db_out[WIDTH-1].
- zero_out  out  1  db_out == 0.
- parity_out  out  1  1 when db_out has an even number of ones.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy=0, done=0, db_out=0, cy_out=0. Flag outputs follow db_out, so sign=0, zero=1, parity=1. An operation in progress is abandoned; no done is issued.
- States: IDLE, SHIFT, DONE.
- IDLE, start=1: latch db_in into the data register, cy_in into the carry register, latch mode, load the step counter with count. Next state is SHIFT if count!=0, otherwise DONE.
- SHIFT: each clock applies one step and decrements the counter. When the counter reaches 1 and that step is applied, next state is DONE.
- DONE: done=1 for exactly one cycle, then IDLE. db_out and cy_out hold until the next accepted start.
- busy=1 in SHIFT and DONE; busy=0 in IDLE.
- start while busy is ignored; no queueing.
- Latency from start to done: count+1 cycles. count=0 gives done on the next cycle, with db_out=db_in and cy_out=cy_in.
- Left step: d' = {d[WIDTH-2:0], in}; c' = d[WIDTH-1]. The in bit is d[WIDTH-1] for RLC, c for RL, 0 for SLA, 1 for SLL.
- Right step: d' = {in, d[WIDTH-1:1]}; c' = d[0]. The in bit is d[0] for RRC, c for RR, d[WIDTH-1] for SRA, 0 for SRL.
- For RL and RR, the carry register feeds back between steps, giving a (WIDTH+1)-bit rotate.
- Inputs other than start are don't-care after acceptance.
- Flags are combinational from the registered db_out; they are valid whenever done=1 and held afterwards.

Optional Feature:
- Macro name: ALU_SHIFTER_BARREL_EN.
- Defined: a combinational barrel network computes the full count-step result in one pass. Every nonzero count goes IDLE->DONE, latency 1 cycle. Result, carry and flags are bit-identical to the iterative build. SHIFT is unreachable.
- Undefined: iterative behaviour as above.
- Handshake and port list are identical in both builds.

Decomposition:
- Package alu_shifter_pkg holds:
  - typedef enum logic [2:0] shift_mode_t (RLC..SRL, values as listed above);
  - typedef enum state_t {IDLE, SHIFT, DONE}.
- Sub-module alu_shifter_step: combinational single-step function (d, c, mode -> d', c'). It is reused by the iterative path and replicated/unrolled by the barrel path.

Test Plan (WIDTH=8, CNT_W=3, iterative):
- RLC, db_in=0x81, count=1 -> done 2 cycles after start; db_out=0x03, cy_out=1, parity=1.
- RL, db_in=0x80, cy_in=0, count=2 -> db_out=0x01, cy_out=0; busy high for 3 cycles.
- SRA, db_in=0x80, count=3 -> db_out=0xF0, cy_out=0, sign=1. Also SRL, db_in=0x01, count=1 -> db_out=0x00, cy_out=1, zero=1.
- SLL, db_in=0x00, count=2 -> db_out=0x03. RR, db_in=0x01, cy_in=1, count=1 -> db_out=0x80, cy_out=1.
- count=0, db_in=0x55, cy_in=1, any mode -> done next cycle, db_out=0x55, cy_out=1. A second start asserted during busy is ignored, and no extra done is issued.
- Assert nreset mid-SHIFT (RLC, count=7, after 3 steps) -> busy=0, done=0, db_out=0 immediately. Then a new start behaves normally.
- Repeat all scenarios with ALU_SHIFTER_BARREL_EN -> identical results, with done one cycle after start.
